seq_shift_add_multiplier: RTL and testbench
===========================================

# seq_shift_add_multiplier

Iterative radix-2 unsigned shift-add multiplier producing a 2W-bit product from two W-bit operands, one multiplier bit per clock. It sits directly upstream of the 56-bit + 55-bit custom adder stage. With W = 28 its 56-bit product is that adder's wide operand. A valid/ready handshake on both sides lets the adder stage apply backpressure.

## Interface
- W, default 28: operand width; product is 2W bits; legal range 2..64.
- CW, default 7: iteration counter width; must satisfy 2^CW > W.

- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; high only in IDLE.
- op_a  input  W  multiplicand, unsigned.
- op_b  input  W  multiplier, unsigned.
- out_valid  output  1  product valid; held until consumed.
- out_ready  input  1  downstream accepts product.
- product  output  2W  unsigned op_a*op_b, registered.
- busy  output  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: W iterations.
  - DONE: out_valid=1.
- IDLE -> RUN on in_valid at a clock edge (accept):
  - a_reg <= op_a.
  - P <= {W zeros, op_b}.
  - cnt <= 0.
- RUN, each edge:
  - s = P[2W-1:W] + (P[0] ? a_reg : 0), computed W+1 bits wide with no truncation.
  - P <= {s, P[W-1:1]}.
  - cnt <= cnt+1.
  - When cnt == W-1, state <= DONE.
- DONE:
  - product = P.
  - On out_ready at an edge, state <= IDLE.
  - product holds its value; only out_valid drops.
- Arithmetic: P never overflows 2W bits, because max partial sum < 2^(W+1) and the top bit shifts down each cycle. Result is exact for all inputs.
- in_valid in RUN/DONE: ignored, not queued; upstream must hold it until in_ready.
- op_a/op_b are sampled only at the accept edge; later changes have no effect.
- Reset:
  - rst high at an edge forces IDLE, P=0, cnt=0, a_reg=0, product=0.
  - Reset overrides any simultaneous accept or handshake.
  - Reset mid-RUN discards the operation; no out_valid is produced for it.
- Zero operands need no special path; they still take W cycles.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0. These are visible in the cycle after the rst edge.
- Latency: accept at edge E, out_valid high from edge E+W. For W=28, out_valid rises 28 cycles after acceptance.
- in_ready falls at edge E and rises at the edge where out_valid & out_ready is sampled.
- Minimum initiation interval: W+2 cycles (accept, W iterations, one DONE cycle with out_ready high, then IDLE).
- out_valid stays high and product stays stable for as long as out_ready is low; no data loss.
- out_ready high while out_valid is low has no effect.
- All outputs are registered or decoded only from state; no combinational path from in_valid/out_ready to in_ready/out_valid.

## Test plan
- Reset then idle, 5 cycles:
  - in_ready=1, out_valid=0, busy=0, product=0.
- op_a=3, op_b=5, out_ready=1:
  - out_valid exactly 28 cycles after accept.
  - product=15.
  - in_ready high again the following cycle.
- op_a=op_b=0xFFFFFFF (all ones):
  - product=0xFFFFFFE0000001; confirms no overflow in top partial sum.
- Backpressure, op_a=0x1234567, op_b=0:
  - product=0.
  - Hold out_ready low 10 cycles: out_valid and product stable, in_ready=0, new in_valid ignored.
  - Raise out_ready: one handshake, then IDLE.
- Reset mid-RUN: assert rst at iteration 10 of op_a=7, op_b=9:
  - Next cycle in_ready=1, out_valid=0.
  - No product ever emitted.
  - Next operation 6*7 yields 42.
- Back-to-back with in_valid held high and out_ready=1, 100 random W=28 pairs:
  - Every product matches the reference a*b.
  - Accepts spaced exactly 30 cycles apart.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Iterative radix-2 unsigned shift-add multiplier. It retires one multiplier
// bit per clock and produces a 2W-bit product after W iterations. Operands and
// results move over valid/ready handshakes, so the downstream adder stage can
// apply backpressure.
//
// Parameters
//   W   operand width (2..64); the product is 2W bits wide
//   CW  iteration counter width; 2^CW must exceed W
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair offered by upstream
//   in_ready   block can accept (high only in IDLE)
//   op_a       multiplicand, unsigned, sampled at the accept edge
//   op_b       multiplier, unsigned, sampled at the accept edge
//   out_valid  product valid; held until consumed
//   out_ready  downstream accepts the product
//   product    registered op_a*op_b; holds its value after the handshake
//   busy       high while in RUN or DONE
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int W  = 28,
    parameter int CW = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [2*W-1:0]   r_p;
    logic [CW-1:0]    r_cnt;
    logic [2*W-1:0]   r_product;

    logic [W:0]       w_sum;
    logic [2*W-1:0]   w_p_next;

    // One iteration: add the multiplicand into the upper half when the current
    // multiplier bit (P[0]) is set, then shift the whole accumulator right.
    // The sum is kept W+1 bits wide; its carry lands in bit 2W-1 of the
    // shifted accumulator, so nothing is ever lost.
    // NOTE: every signal assigned in always_comb gets an unconditional value,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sum    = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_a} : '0);
        w_p_next = {w_sum, r_p[W-1:1]};
    end

    // NOTE: state registers use non-blocking assignments so every register
    // sees pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the control and datapath registers are cleared here;
            // reset wins over any simultaneous accept or handshake.
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_p     <= {{W{1'b0}}, op_b};
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        // Capture the finished product on the final iteration
                        // so it is registered when out_valid rises.
                        r_product <= w_p_next;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode only the state register, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//
// Directed bench for seq_shift_add_multiplier at W=28. Expected products are
// pushed to a scoreboard queue at each accept and compared when the product is
// handed off. Inputs change and outputs are sampled 1 time unit after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

    localparam int W  = 28;
    localparam int CW = 7;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    seq_shift_add_multiplier #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] sb[$];

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock. If a handshake will happen at this edge, compare the
    // product against the oldest scoreboard entry first.
    task automatic step();
        logic [63:0] exp_p;
        if (out_valid && out_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_p = sb.pop_front();
                check("product", {8'b0, product}, exp_p);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Offer one pair, push its reference product and wait for out_valid,
    // checking the latency. Leaves the DUT in DONE; out_ready is untouched.
    task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input string tag);
        int n;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        sb.push_back(64'(a) * 64'(b));
        step();                                   // accept edge E
        in_valid = 1'b0;
        op_a     = ~a;                            // later changes must not matter
        op_b     = ~b;
        check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        check({tag, "_busy_high"},    64'(busy),     64'd1);
        n = 0;
        while (!out_valid && n < W + 5) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(W));
    endtask

    initial begin
        logic        seen_valid;
        int          prev_acc;
        int          acc;
        int          guard;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state held while idle.
        for (int i = 0; i < 5; i++) begin
            check_idle("reset");
            check("reset_product", {8'b0, product}, 64'd0);
            step();
        end

        // 3 * 5 with the consumer always ready.
        out_ready = 1'b1;
        issue_and_wait(28'd3, 28'd5, "small");
        step();                                   // handshake edge
        check_idle("small_after");

        // All-ones operands: largest partial sums.
        issue_and_wait(28'hFFF_FFFF, 28'hFFF_FFFF, "ones");
        check("ones_product_value", {8'b0, product}, 64'h00FF_FFFF_E000_0001);
        step();
        check_idle("ones_after");

        // Backpressure: product 0 held for 10 cycles, new offers ignored.
        out_ready = 1'b0;
        issue_and_wait(28'h123_4567, 28'd0, "bp");
        in_valid = 1'b1;
        op_a     = 28'd5;
        op_b     = 28'd5;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_out_valid", 64'(out_valid),       64'd1);
            check("bp_product",   {8'b0, product},      64'd0);
            check("bp_in_ready",  64'(in_ready),        64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();                                   // single handshake
        check_idle("bp_after");
        step();
        step();
        check_idle("bp_stays_idle");
        check("bp_sb_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a run: operation discarded.
        op_a     = 28'd7;
        op_b     = 28'd9;
        in_valid = 1'b1;
        step();                                   // accept edge E
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();                                   // edge E+10 under reset
        rst = 1'b0;
        check_idle("midrst");
        check("midrst_product", {8'b0, product}, 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            seen_valid |= out_valid;
            step();
        end
        check("midrst_no_output", 64'(seen_valid), 64'd0);

        issue_and_wait(28'd6, 28'd7, "after_rst");
        check("after_rst_value", {8'b0, product}, 64'd42);
        step();
        check_idle("after_rst_idle");

        // Back-to-back random pairs with in_valid held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 100; i++) begin
            ra   = W'($urandom());
            rb   = W'($urandom());
            op_a = ra;
            op_b = rb;
            guard = 0;
            while (!in_ready && guard < 2 * W) begin
                step();
                guard++;
            end
            check("b2b_ready_seen", 64'(in_ready), 64'd1);
            acc = cyc + 1;                        // next edge accepts
            sb.push_back(64'(ra) * 64'(rb));
            if (i > 0) check("b2b_interval", 64'(acc - prev_acc), 64'(W + 2));
            prev_acc = acc;
            step();
        end
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 2 * W) begin
            step();
            guard++;
        end
        check("b2b_sb_drained", 64'(sb.size()), 64'd0);
        step();
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
